// File: rtl/mbist_pkg.sv
// mbist_pkg: shared types and entry layout for the MBIST fail logger
package mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CLOSED
    } state_e;

    localparam int STAMP_W = 16;

    // Entry layout, LSB first: stamp, aligned address, newly-failing mask
    function automatic int mask_lsb(input int addr_w);
        return STAMP_W + addr_w + 1;
    endfunction

    function automatic int entry_w(input int enum_n, input int addr_w);
        return mask_lsb(addr_w) + enum_n;
    endfunction

endpackage

// File: rtl/mbist_log_fifo.sv
// mbist_log_fifo: synchronous FIFO with flush, accepting a push into a full FIFO only alongside a pop
module mbist_log_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    // Storage is reset so the head reads as zero out of reset; a flush only rewinds pointers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/mbist_fail_logger.sv
// mbist_fail_logger: logs each newly-failing UUT event with its aligned address and cycle stamp
module mbist_fail_logger
    import mbist_pkg::*;
#(
    parameter int ENUM     = 10,
    parameter int ADDR_W   = 8,
    parameter int ADDR_DLY = 2,
    parameter int DEPTH    = 8
) (
    input  logic                     bist_clk,
    input  logic                     rst_l,
    input  logic                     tst_start,
    input  logic [ADDR_W:0]          tst_ADDRA,
    input  logic [ENUM:1]            inter_fail,
    input  logic                     tst_done,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [ENUM:1]            rd_mask,
    output logic [ADDR_W:0]          rd_addr,
    output logic [STAMP_W-1:0]       rd_stamp,
    output logic [$clog2(DEPTH):0]   log_count,
    output logic                     log_ovf,
    output logic                     armed
);

    localparam int EW = entry_w(ENUM, ADDR_W);
    localparam int ML = mask_lsb(ADDR_W);

    state_e             state_q, state_d;
    logic               done_q, ovf_q, push, pop, full, empty;
    logic [ENUM:1]      fail_q, new_fail;
    logic [STAMP_W-1:0] stamp_q;
    logic [ADDR_W:0]    dly_q [ADDR_DLY];
    logic [EW-1:0]      wdata, rdata;

    assign armed    = state_q == ST_ARMED;
    assign new_fail = inter_fail & ~fail_q;
    assign push     = armed & (|new_fail) & ~tst_start;
    assign pop      = rd_valid & rd_ready;
    assign rd_valid = ~empty;
    assign log_ovf  = ovf_q;
    assign wdata    = {new_fail, dly_q[ADDR_DLY-1], stamp_q};
    assign rd_mask  = rdata[EW-1:ML];
    assign rd_addr  = rdata[ML-1:STAMP_W];
    assign rd_stamp = rdata[STAMP_W-1:0];

    // Start always (re)arms; only a rising done closes an armed run
    always_comb begin
        state_d = tst_start ? ST_ARMED :
                  (armed && tst_done && !done_q) ? ST_CLOSED : state_q;
    end

    // FSM, done edge history, fail edge detector, saturating stamp and overflow flag
    always_ff @(posedge bist_clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            fail_q  <= '0;
            stamp_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= tst_done;
            if (tst_start) begin
                fail_q  <= '0;
                stamp_q <= '0;
                ovf_q   <= 1'b0;
            end else if (armed) begin
                fail_q  <= inter_fail;
                stamp_q <= stamp_q + STAMP_W'(stamp_q != '1);
                if (push && full && !pop) ovf_q <= 1'b1;
            end
        end
    end

    // Address delay line so the logged address matches the comparator latency
    always_ff @(posedge bist_clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < ADDR_DLY; i++) dly_q[i] <= '0;
        end else if (tst_start) begin
            for (int i = 0; i < ADDR_DLY; i++) dly_q[i] <= '0;
        end else begin
            dly_q[0] <= tst_ADDRA;
            for (int i = 1; i < ADDR_DLY; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    mbist_log_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (bist_clk),
        .rst_ni  (rst_l),
        .clr_i   (tst_start),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (log_count)
    );

endmodule
